// File: rtl/rat_io_pkg.sv
// Shared I/O constants for the RAT board wrapper: port IDs, the seven-segment
// font and the digit-select encoding used by the display multiplexer.
package rat_io_pkg;

  localparam logic [7:0] SWITCHES_ID = 8'h20;
  localparam logic [7:0] LEDS_ID     = 8'h40;
  localparam logic [7:0] SSEG_ID     = 8'h81;
  localparam logic [7:0] SSEG_BLANK  = 8'hFF;

  // Active-low {DP, g..a}; DP bit is 1 (off) in every entry.
  localparam logic [7:0] HEX_FONT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic [1:0] {
    DIGIT_LO      = 2'd0,
    DIGIT_HI      = 2'd1,
    DIGIT_BLANK_2 = 2'd2,
    DIGIT_BLANK_3 = 2'd3
  } digit_e;

endpackage

// File: rtl/rat_mcu.sv
// Behavioural stand-in for the RAT core: the port bus is driven from the
// *_drv variables, which a unit bench sets hierarchically.
module rat_mcu (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       INT,
  input  logic [7:0] IN_PORT,
  output logic [7:0] OUT_PORT,
  output logic [7:0] PORT_ID,
  output logic       IO_STRB
);

  logic [7:0] out_port_drv = '0;
  logic [7:0] port_id_drv  = '0;
  logic       io_strb_drv  = 1'b0;

  assign OUT_PORT = out_port_drv;
  assign PORT_ID  = port_id_drv;
  assign IO_STRB  = io_strb_drv;

  logic unused_inputs;
  assign unused_inputs = ^{CLK, RESET, INT, IN_PORT};

endmodule

// File: rtl/sseg_mux.sv
// Four-digit multiplexed seven-segment driver: shows the display register as
// two hex digits on the right, leaving the left two digits blank.
module sseg_mux
  import rat_io_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] disp_val,
  output logic [7:0] sseg,
  output logic [3:0] disp_en
);

  logic [REFRESH_BITS-1:0] refresh_cnt;
  digit_e                  sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) refresh_cnt <= '0;
    else        refresh_cnt <= refresh_cnt + 1'b1;
  end

  assign sel = digit_e'(refresh_cnt[REFRESH_BITS-1 -: 2]);

  always_comb begin
    disp_en = ~(4'b0001 << sel);
    sseg    = SSEG_BLANK;
    unique case (sel)
      DIGIT_LO: sseg = HEX_FONT[disp_val[3:0]];
      DIGIT_HI: sseg = HEX_FONT[disp_val[7:4]];
      default:  sseg = SSEG_BLANK;
    endcase
  end

endmodule

// File: rtl/rat_wrapper.sv
// Board-level top for the RAT microcontroller: port-bus decode, LED/display
// registers, button-to-interrupt shaping and the seven-segment driver.
module rat_wrapper
  import rat_io_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = 17,
  parameter int unsigned INT_STRETCH  = 2
) (
  input  logic       CLK,
  input  logic       BTNC,
  input  logic       BTNL,
  input  logic [7:0] SWITCHES,
  output logic [7:0] LEDS,
  output logic [7:0] SSEG,
  output logic [3:0] DISP_EN
);

  localparam int unsigned STRETCH_W = $clog2(INT_STRETCH + 1);

  logic                 mcu_reset;
  logic [7:0]           in_port;
  logic [7:0]           out_port;
  logic [7:0]           port_id;
  logic                 io_strb;
  logic                 int_req;
  logic [7:0]           disp_reg;
  logic                 btnl_meta;
  logic                 btnl_sync;
  logic                 btnl_prev;
  logic                 edge_q;
  logic [STRETCH_W-1:0] stretch_cnt;

  assign mcu_reset = ~BTNC;

  rat_mcu u_mcu (
    .CLK      (CLK),
    .RESET    (mcu_reset),
    .INT      (int_req),
    .IN_PORT  (in_port),
    .OUT_PORT (out_port),
    .PORT_ID  (port_id),
    .IO_STRB  (io_strb)
  );

  assign in_port = (port_id == SWITCHES_ID) ? SWITCHES : '0;

  always_ff @(posedge CLK or negedge BTNC) begin
    if (!BTNC) begin
      LEDS     <= '0;
      disp_reg <= '0;
    end else if (io_strb) begin
      if (port_id == LEDS_ID) LEDS     <= out_port;
      if (port_id == SSEG_ID) disp_reg <= out_port;
    end
  end

  // Registered edge strobe puts the counter load three cycles after the
  // first sample of BTNL; a fresh edge reloads an already-running count.
  always_ff @(posedge CLK or negedge BTNC) begin
    if (!BTNC) begin
      btnl_meta   <= 1'b0;
      btnl_sync   <= 1'b0;
      btnl_prev   <= 1'b0;
      edge_q      <= 1'b0;
      stretch_cnt <= '0;
    end else begin
      btnl_meta <= BTNL;
      btnl_sync <= btnl_meta;
      btnl_prev <= btnl_sync;
      edge_q    <= btnl_sync & ~btnl_prev;
      if (edge_q)                 stretch_cnt <= STRETCH_W'(INT_STRETCH);
      else if (stretch_cnt != '0) stretch_cnt <= stretch_cnt - 1'b1;
    end
  end

  assign int_req = (stretch_cnt != '0);

  sseg_mux #(
    .REFRESH_BITS (REFRESH_BITS)
  ) u_sseg_mux (
    .clk      (CLK),
    .rst_n    (BTNC),
    .disp_val (disp_reg),
    .sseg     (SSEG),
    .disp_en  (DISP_EN)
  );

endmodule

// File: tb/tb_rat_wrapper.sv
// Directed bench for rat_wrapper: bus decode, interrupt shaping, display scan
// and asynchronous reset, with hand-computed expectations.
module tb_rat_wrapper;

  logic       CLK = 1'b0;
  logic       BTNC = 1'b0;
  logic       BTNL = 1'b0;
  logic [7:0] SWITCHES = '0;
  logic [7:0] LEDS;
  logic [7:0] SSEG;
  logic [3:0] DISP_EN;

  int total = 0;
  int bad   = 0;

  int   int_hi = 0;
  int   int_pulses = 0;
  logic int_prev = 1'b0;
  logic [3:0] ref_cnt;

  rat_wrapper #(
    .REFRESH_BITS (4),
    .INT_STRETCH  (2)
  ) dut (
    .CLK      (CLK),
    .BTNC     (BTNC),
    .BTNL     (BTNL),
    .SWITCHES (SWITCHES),
    .LEDS     (LEDS),
    .SSEG     (SSEG),
    .DISP_EN  (DISP_EN)
  );

  always #5 CLK = ~CLK;

  // Independent model of a 4-bit free-running refresh counter.
  always @(posedge CLK or negedge BTNC) begin
    if (!BTNC) ref_cnt <= '0;
    else       ref_cnt <= ref_cnt + 4'd1;
  end

  always @(negedge CLK) begin
    if (dut.int_req) int_hi = int_hi + 1;
    if (dut.int_req && !int_prev) int_pulses = int_pulses + 1;
    int_prev = dut.int_req;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_cycle(input logic [7:0] id, input logic [7:0] data);
    @(negedge CLK);
    dut.u_mcu.port_id_drv  = id;
    dut.u_mcu.out_port_drv = data;
    dut.u_mcu.io_strb_drv  = 1'b1;
    @(negedge CLK);
    dut.u_mcu.io_strb_drv  = 1'b0;
    dut.u_mcu.port_id_drv  = '0;
  endtask

  task automatic clear_int_counts();
    @(negedge CLK);
    #1;
    int_hi     = 0;
    int_pulses = 0;
  endtask

  task automatic wait_negedges(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic check_display(input string tag, input logic [7:0] lo_seg, input logic [7:0] hi_seg);
    logic [1:0] sel;
    logic [3:0] exp_en;
    logic [7:0] exp_seg;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      sel = ref_cnt[3:2];
      case (sel)
        2'd0:    begin exp_en = 4'b1110; exp_seg = lo_seg; end
        2'd1:    begin exp_en = 4'b1101; exp_seg = hi_seg; end
        2'd2:    begin exp_en = 4'b1011; exp_seg = 8'hFF;  end
        default: begin exp_en = 4'b0111; exp_seg = 8'hFF;  end
      endcase
      check({tag, "_en"},   32'(DISP_EN), 32'(exp_en));
      check({tag, "_sseg"}, 32'(SSEG),    32'(exp_seg));
    end
  endtask

  initial begin
    // Reset state.
    #1;
    check("rst_leds",    32'(LEDS),    32'h00);
    check("rst_disp_en", 32'(DISP_EN), 32'h0E);
    check("rst_sseg",    32'(SSEG),    32'hC0);
    check("rst_int",     32'(dut.int_req), 32'd0);
    wait_negedges(3);
    BTNC = 1'b1;
    #1;
    check("mcu_reset_released", 32'(dut.mcu_reset), 32'd0);

    // Switch read mux.
    SWITCHES = 8'h3C;
    dut.u_mcu.port_id_drv = 8'h20;
    #1 check("in_port_sw", 32'(dut.in_port), 32'h3C);
    dut.u_mcu.port_id_drv = 8'h21;
    #1 check("in_port_other", 32'(dut.in_port), 32'h00);
    SWITCHES = 8'hA5;
    dut.u_mcu.port_id_drv = 8'h20;
    #1 check("in_port_sw2", 32'(dut.in_port), 32'hA5);
    dut.u_mcu.port_id_drv = 8'h00;

    // LED register writes.
    bus_cycle(8'h40, 8'hA5);
    check("leds_write", 32'(LEDS), 32'hA5);
    bus_cycle(8'h41, 8'h3C);
    check("leds_wrong_id", 32'(LEDS), 32'hA5);
    bus_cycle(8'h81, 8'h11);
    check("leds_sseg_id", 32'(LEDS), 32'hA5);

    // One-cycle BTNL pulse: INT high for posedges k+3 and k+4 only.
    @(negedge CLK) BTNL = 1'b1;
    @(negedge CLK) BTNL = 1'b0;
    check("int_lat_k0", 32'(dut.int_req), 32'd0);
    @(negedge CLK) check("int_lat_k1", 32'(dut.int_req), 32'd0);
    @(negedge CLK) check("int_lat_k2", 32'(dut.int_req), 32'd0);
    @(negedge CLK) check("int_lat_k3", 32'(dut.int_req), 32'd1);
    @(negedge CLK) check("int_lat_k4", 32'(dut.int_req), 32'd1);
    @(negedge CLK) check("int_lat_k5", 32'(dut.int_req), 32'd0);

    // Three separated pulses.
    clear_int_counts();
    for (int p = 0; p < 3; p++) begin
      @(negedge CLK) BTNL = 1'b1;
      @(negedge CLK) BTNL = 1'b0;
      wait_negedges(30);
    end
    #1;
    check("three_pulses_cnt", 32'(int_pulses), 32'd3);
    check("three_pulses_hi",  32'(int_hi),     32'd6);

    // BTNL held high: single pulse.
    clear_int_counts();
    @(negedge CLK) BTNL = 1'b1;
    wait_negedges(10);
    BTNL = 1'b0;
    wait_negedges(8);
    #1;
    check("held_pulses", 32'(int_pulses), 32'd1);
    check("held_hi",     32'(int_hi),     32'd2);

    // Second edge while INT high reloads: one 4-cycle pulse.
    clear_int_counts();
    @(negedge CLK) BTNL = 1'b1;
    @(negedge CLK) BTNL = 1'b0;
    @(negedge CLK) BTNL = 1'b1;
    @(negedge CLK) BTNL = 1'b0;
    wait_negedges(10);
    #1;
    check("reload_pulses", 32'(int_pulses), 32'd1);
    check("reload_hi",     32'(int_hi),     32'd4);

    // BTNL edge coinciding with an LED strobe.
    @(negedge CLK);
    BTNL = 1'b1;
    dut.u_mcu.port_id_drv  = 8'h40;
    dut.u_mcu.out_port_drv = 8'h5A;
    dut.u_mcu.io_strb_drv  = 1'b1;
    @(negedge CLK);
    BTNL = 1'b0;
    dut.u_mcu.io_strb_drv = 1'b0;
    dut.u_mcu.port_id_drv = '0;
    check("simul_leds", 32'(LEDS), 32'h5A);
    wait_negedges(2);
    check("simul_int_k2", 32'(dut.int_req), 32'd0);
    @(negedge CLK) check("simul_int_k3", 32'(dut.int_req), 32'd1);
    wait_negedges(4);

    // Display scan.
    bus_cycle(8'h81, 8'h7E);
    check_display("disp_7e", 8'h86, 8'hF8);
    bus_cycle(8'h81, 8'hB9);
    check_display("disp_b9", 8'h90, 8'h83);
    bus_cycle(8'h40, 8'h81);
    check_display("disp_kept", 8'h90, 8'h83);

    // Asynchronous reset while INT is high.
    @(negedge CLK) BTNL = 1'b1;
    @(negedge CLK) BTNL = 1'b0;
    wait_negedges(3);
    check("pre_rst_int", 32'(dut.int_req), 32'd1);
    #2 BTNC = 1'b0;
    #1;
    check("mid_rst_leds",    32'(LEDS),          32'h00);
    check("mid_rst_disp_en", 32'(DISP_EN),       32'h0E);
    check("mid_rst_sseg",    32'(SSEG),          32'hC0);
    check("mid_rst_int",     32'(dut.int_req),   32'd0);
    check("mid_rst_mcu",     32'(dut.mcu_reset), 32'd1);
    @(negedge CLK) BTNC = 1'b1;
    wait_negedges(2);
    check("post_rst_leds", 32'(LEDS),        32'h00);
    check("post_rst_int",  32'(dut.int_req), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
